// File: rtl/sweep_counter.sv
// rtl/sweep_counter.sv - prescaled sawtooth/triangle position sweep counter
// Optional load path is built only when SWEEP_COUNTER_LOAD_EN is defined;
// otherwise load/load_val stay on the port list and are ignored.
module sweep_counter #(
  parameter int WIDTH    = 15,
  parameter int PRESCALE = 100,
  parameter int MAX_VAL  = 20000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cntd_val,
  output logic             dir,
  output logic             step,
  output logic             turn
);

  localparam logic [15:0]      PRE_LAST = 16'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] MAXV     = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [15:0]      presc;
  logic             tick;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] next_val;
  logic             next_dir;
  logic             next_turn;

  assign tick = en && (presc == PRE_LAST);

`ifdef SWEEP_COUNTER_LOAD_EN
  logic [WIDTH-1:0] load_clamped;
  assign load_clamped = (load_val > MAXV) ? MAXV : load_val;
`else
  logic unused_load;
  assign unused_load = ^{load, load_val};
`endif

  // Next position/direction for a tick; out-of-range values are treated as the top
  always_comb begin
    cur       = (cntd_val > MAXV) ? MAXV : cntd_val;
    next_val  = cur;
    next_dir  = dir;
    next_turn = 1'b0;
    if (!mode) begin
      next_dir = 1'b1;
      if (cur == MAXV) begin
        next_val  = '0;
        next_turn = 1'b1;
      end else begin
        next_val = cur + ONE;
      end
    end else if (dir) begin
      if (cur == MAXV) begin
        next_dir  = 1'b0;
        next_val  = MAXV - ONE;
        next_turn = 1'b1;
      end else begin
        next_val = cur + ONE;
      end
    end else begin
      if (cur == '0) begin
        next_dir  = 1'b1;
        next_val  = ONE;
        next_turn = 1'b1;
      end else begin
        next_val = cur - ONE;
      end
    end
  end

  // Prescaler, position, direction and the registered step/turn pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= '0;
      cntd_val <= '0;
      dir      <= 1'b1;
      step     <= 1'b0;
      turn     <= 1'b0;
    end
`ifdef SWEEP_COUNTER_LOAD_EN
    else if (load) begin
      // load wins over a coincident tick and restarts the prescale interval
      presc    <= '0;
      cntd_val <= load_clamped;
      step     <= 1'b0;
      turn     <= 1'b0;
    end
`endif
    else begin
      step <= tick;
      turn <= tick && next_turn;
      if (en) begin
        presc <= tick ? 16'd0 : presc + 16'd1;
        if (tick) begin
          cntd_val <= next_val;
          dir      <= next_dir;
        end else if (!mode) begin
          // leaving triangle mode: sawtooth always counts up
          dir <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/sweep_counter.md
SWEEP_COUNTER -- requirements
Module: sweep_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 15, meaning bit width of the position value.
REQ-002 SHALL have parameter PRESCALE, default 100, meaning clock cycles per value step (legal range 1..65535).
REQ-003 SHALL have parameter MAX_VAL, default 20000, meaning top of sweep range (legal range 1..2**WIDTH-1).
REQ-004 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port en  input  1  count enable; when low, prescaler and value hold.
REQ-007 SHALL have port mode  input  1  0 = sawtooth (0..MAX_VAL, wrap), 1 = triangle (0..MAX_VAL..0).
REQ-008 SHALL have port load  input  1  synchronous load strobe.
REQ-009 SHALL have port load_val  input  WIDTH  value to load.
REQ-010 SHALL have port cntd_val  output  WIDTH  registered position value.
REQ-011 SHALL have port dir  output  1  registered direction, 1 = counting up.
REQ-012 SHALL have port step  output  1  one-cycle pulse in the cycle cntd_val changes due to a prescaler tick.
REQ-013 SHALL have port turn  output  1  one-cycle pulse in the cycle cntd_val wraps to 0 (mode 0) or reverses direction (mode 1).

Function
REQ-014 Prescaler SHALL count 0..PRESCALE-1 while en=1; internal tick when prescaler = PRESCALE-1 and en=1, prescaler returning to 0.
REQ-015 With PRESCALE=1, a tick SHALL occur on every clock with en=1.
REQ-016 Value SHALL change only on a tick or a load; first step after reset lands exactly PRESCALE enabled cycles after reset release.
REQ-017 Mode 0 tick: cntd_val = MAX_VAL -> 0 with turn=1; otherwise cntd_val+1; dir held at 1.
REQ-018 Mode 1 tick, dir=1: cntd_val = MAX_VAL -> dir<=0, cntd_val<=MAX_VAL-1, turn=1; otherwise cntd_val+1.
REQ-019 Mode 1 tick, dir=0: cntd_val = 0 -> dir<=1, cntd_val<=1, turn=1; otherwise cntd_val-1.
REQ-020 Switching mode 1 -> 0 SHALL set dir<=1 on the next clock; value unchanged until next tick.
REQ-021 Switching mode 0 -> 1 SHALL continue from current value counting up.
REQ-022 If cntd_val > MAX_VAL at a tick (only possible via load, see REQ-024), it SHALL be treated as MAX_VAL.
REQ-023 step and turn SHALL be registered, asserted the same cycle the new cntd_val is visible, and never for more than one cycle per tick.
REQ-024 load=1 SHALL take priority over tick: cntd_val <= min(load_val, MAX_VAL), prescaler <= 0, dir unchanged, step=0, turn=0.
REQ-025 en=0 SHALL freeze prescaler, cntd_val and dir; load SHALL still act when en=0.
REQ-026 Arithmetic SHALL be unsigned WIDTH-bit; no value outside 0..MAX_VAL SHALL appear on cntd_val.

Reset
REQ-027 rst_n low SHALL immediately set cntd_val=0, dir=1, step=0, turn=0, prescaler=0, independent of clk.
REQ-028 Reset assertion mid-sweep or mid-prescale SHALL discard all progress; no step within PRESCALE cycles of release.

Configuration
REQ-029 Macro SWEEP_COUNTER_LOAD_EN: when defined, load/load_val behave per REQ-024/REQ-025.
REQ-030 Without SWEEP_COUNTER_LOAD_EN, load and load_val SHALL remain as ports but be ignored; no load logic synthesised.

Verification (PRESCALE=4, MAX_VAL=5, WIDTH=4 unless noted)
REQ-031 Reset release, en=1, mode=0 -> cntd_val 1 at cycle 4, 2 at cycle 8, ..., 5 at cycle 20, 0 with turn=1 at cycle 24.
REQ-032 mode=1, en=1 from reset -> sequence 0,1,2,3,4,5,4,3,2,1,0,1; turn pulses at the 5->4 and 0->1 steps; dir toggles with them.
REQ-033 en dropped for 10 cycles at prescaler=2 -> cntd_val and step frozen; next step exactly 2 enabled cycles after en returns.
REQ-034 SWEEP_COUNTER_LOAD_EN defined, load=1 load_val=9 coincident with tick -> cntd_val=5, step=0, next step 4 cycles later (mode 0: to 0 with turn=1).
REQ-035 rst_n pulsed low asynchronously between clk edges at cntd_val=3 -> outputs zero before next edge, dir=1; PRESCALE=1 build: step every cycle, 0..5 wrap in 6 cycles.
